// File: rtl/rd_req_arbiter_pkg.sv
// Shared read-path constants and types for the host read-request channel.
// Imported by the arbiter and its counter.
package rd_req_arbiter_pkg;

  localparam int READ_RESP_FIFO_DEPTH = 512;

  localparam logic [15:0] READ_CTRL_MDATA = 16'h0001;
  localparam logic [15:0] READ_RUN_MDATA  = 16'h0002;

  typedef enum logic {
    SRC_CTRL,
    SRC_RUN
  } e_rd_req_src;

endpackage

// File: rtl/rd_credit_counter.sv
// Saturating up/down counter used for credits and in-flight reads.
// err pulses when an inc at MAX or a dec at zero is absorbed.
module rd_credit_counter
  import rd_req_arbiter_pkg::*;
#(
  parameter int           W    = 10,
  parameter logic [W-1:0] INIT = '0,
  parameter logic [W-1:0] MAX  = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         err
);

  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    err       = 1'b0;
    if (inc && !dec) begin
      if (count == MAX) err = 1'b1;
      else count_nxt = count + W'(1);
    end else if (dec && !inc) begin
      if (count == '0) err = 1'b1;
      else count_nxt = count - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count <= INIT;
    else       count <= count_nxt;
  end

endmodule

// File: rtl/rd_req_arbiter.sv
// Round-robin CTRL/RUN arbiter for the c0Tx read channel with exact
// credit flow control against the read response FIFO.
module rd_req_arbiter
  import rd_req_arbiter_pkg::*;
#(
  parameter int RESP_FIFO_DEPTH      = READ_RESP_FIFO_DEPTH,
  parameter int CTRL_MAX_OUTSTANDING = 1,
  parameter int CL_ADDR_W            = 42,
  parameter int MDATA_W              = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_enable,
  input  logic                  ctrl_req_valid,
  input  logic [CL_ADDR_W-1:0]  ctrl_req_addr,
  output logic                  ctrl_req_ready,
  input  logic                  run_req_valid,
  input  logic [CL_ADDR_W-1:0]  run_req_addr,
  output logic                  run_req_ready,
  input  logic                  tx_alm_full,
  input  logic                  rx_rsp_valid,
  input  logic [MDATA_W-1:0]    rx_rsp_mdata,
  input  logic                  fifo_pop,
  output logic                  req_valid,
  output logic [CL_ADDR_W-1:0]  req_addr,
  output logic [MDATA_W-1:0]    req_mdata,
  output logic [$clog2(RESP_FIFO_DEPTH+1)-1:0]      run_credits,
  output logic [$clog2(CTRL_MAX_OUTSTANDING+1)-1:0] ctrl_outstanding,
  output logic [31:0]           run_outstanding,
  output logic [1:0]            err_sticky
);

  localparam int CREDIT_W = $clog2(RESP_FIFO_DEPTH+1);
  localparam int CTRL_W   = $clog2(CTRL_MAX_OUTSTANDING+1);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(RESP_FIFO_DEPTH);
  localparam logic [CTRL_W-1:0]   CTRL_MAX   = CTRL_W'(CTRL_MAX_OUTSTANDING);
  localparam logic [MDATA_W-1:0]  CTRL_MD    = MDATA_W'(READ_CTRL_MDATA);
  localparam logic [MDATA_W-1:0]  RUN_MD     = MDATA_W'(READ_RUN_MDATA);

  e_rd_req_src last_grant;

  logic ctrl_elig;
  logic run_elig;
  logic ctrl_grant;
  logic run_grant;
  logic ctrl_rsp;
  logic run_rsp;
  logic credit_err;
  logic ctrl_err;
  logic run_err;

  assign ctrl_elig = ctrl_req_valid && !tx_alm_full &&
                     (ctrl_outstanding < CTRL_MAX);
  assign run_elig  = run_req_valid && run_enable && !tx_alm_full &&
                     (run_credits != '0);

  // On a tie, the requester that did not win last time goes first.
  assign ctrl_grant = ctrl_elig && (!run_elig || last_grant == SRC_RUN);
  assign run_grant  = run_elig && (!ctrl_elig || last_grant == SRC_CTRL);

  assign ctrl_req_ready = ctrl_grant;
  assign run_req_ready  = run_grant;

  assign ctrl_rsp = rx_rsp_valid && (rx_rsp_mdata == CTRL_MD);
  assign run_rsp  = rx_rsp_valid && (rx_rsp_mdata == RUN_MD);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SRC_RUN;
      req_valid  <= 1'b0;
      req_addr   <= '0;
      req_mdata  <= '0;
      err_sticky <= '0;
    end else begin
      req_valid  <= ctrl_grant || run_grant;
      err_sticky <= err_sticky | {ctrl_err || run_err, credit_err};
      if (ctrl_grant) begin
        last_grant <= SRC_CTRL;
        req_addr   <= ctrl_req_addr;
        req_mdata  <= CTRL_MD;
      end else if (run_grant) begin
        last_grant <= SRC_RUN;
        req_addr   <= run_req_addr;
        req_mdata  <= RUN_MD;
      end
    end
  end

  rd_credit_counter #(
    .W    (CREDIT_W),
    .INIT (CREDIT_MAX),
    .MAX  (CREDIT_MAX)
  ) u_run_credits (
    .clk   (clk),
    .reset (reset),
    .inc   (fifo_pop),
    .dec   (run_grant),
    .count (run_credits),
    .err   (credit_err)
  );

  rd_credit_counter #(
    .W    (CTRL_W),
    .INIT ('0),
    .MAX  ('1)
  ) u_ctrl_outstanding (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl_grant),
    .dec   (ctrl_rsp),
    .count (ctrl_outstanding),
    .err   (ctrl_err)
  );

  rd_credit_counter #(
    .W    (32),
    .INIT ('0),
    .MAX  ('1)
  ) u_run_outstanding (
    .clk   (clk),
    .reset (reset),
    .inc   (run_grant),
    .dec   (run_rsp),
    .count (run_outstanding),
    .err   (run_err)
  );

endmodule
